// File: rtl/pattern_match_ctrl.sv
// Serial bit-pattern matcher: scans cfg_count bits for a 1..8-bit pattern and counts matches.
// Define PATTERN_MATCH_CTRL_OVERLAP_EN to let matches overlap; otherwise history clears per match.
module pattern_match_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_pattern,
  input  logic [2:0] cfg_len,
  input  logic [9:0] cfg_count,
  input  logic       a_valid,
  input  logic       a,
  output logic       a_ready,
  input  logic       abort,
  output logic       detected,
  output logic [7:0] match_count,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_pattern;
  logic [2:0] r_len;
  logic [9:0] r_count;
  logic [7:0] r_hist;
  logic [3:0] r_hist_cnt;
  logic [9:0] r_acc;
  logic       r_detected;
  logic [7:0] r_match_count;

  logic       w_accept;
  logic [7:0] w_hist_next;
  logic [3:0] w_hist_cnt_next;
  logic [7:0] w_mask;
  logic       w_match;
  logic [9:0] w_acc_next;

  assign cfg_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign a_ready     = (r_state == ST_RUN) & ~abort;
  assign detected    = r_detected;
  assign match_count = r_match_count;

  assign w_accept        = a_valid & a_ready;
  // Newest bit enters at bit 0, so hist[len] holds the oldest bit of the window.
  assign w_hist_next     = {r_hist[6:0], a};
  assign w_hist_cnt_next = (r_hist_cnt == 4'd8) ? 4'd8 : r_hist_cnt + 4'd1;
  assign w_mask          = 8'hFF >> (3'd7 - r_len);
  assign w_match         = w_accept & (((w_hist_next ^ r_pattern) & w_mask) == 8'h00) &
                           (w_hist_cnt_next > {1'b0, r_len});
  assign w_acc_next      = r_acc + 10'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pattern     <= '0;
      r_len         <= '0;
      r_count       <= '0;
      r_hist        <= '0;
      r_hist_cnt    <= '0;
      r_acc         <= '0;
      r_detected    <= 1'b0;
      r_match_count <= '0;
    end else begin
      r_detected <= w_match;
      case (r_state)
        ST_IDLE: begin
          if (cfg_valid) begin
            r_pattern     <= cfg_pattern;
            r_len         <= cfg_len;
            r_count       <= cfg_count;
            r_hist        <= '0;
            r_hist_cnt    <= '0;
            r_acc         <= '0;
            r_match_count <= '0;
            r_state       <= (cfg_count == 10'd0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (w_accept) begin
            r_acc <= w_acc_next;
            if (w_match) begin
`ifdef PATTERN_MATCH_CTRL_OVERLAP_EN
              r_hist     <= w_hist_next;
              r_hist_cnt <= w_hist_cnt_next;
`else
              r_hist     <= '0;
              r_hist_cnt <= '0;
`endif
              if (r_match_count != 8'hFF) begin
                r_match_count <= r_match_count + 8'd1;
              end
            end else begin
              r_hist     <= w_hist_next;
              r_hist_cnt <= w_hist_cnt_next;
            end
            if (w_acc_next == r_count) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Scoreboard bench for pattern_match_ctrl: a sequence-level model predicts match pulses and done.
module tb_pattern_match_ctrl;

`ifdef PATTERN_MATCH_CTRL_OVERLAP_EN
  localparam bit Overlap = 1'b1;
`else
  localparam bit Overlap = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic [9:0] cfg_count;
  logic       a_valid;
  logic       a;
  logic       a_ready;
  logic       abort;
  logic       detected;
  logic [7:0] match_count;
  logic       busy;
  logic       done;

  pattern_match_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_count  (cfg_count),
    .a_valid    (a_valid),
    .a          (a),
    .a_ready    (a_ready),
    .abort      (abort),
    .detected   (detected),
    .match_count(match_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_det_idx[$];
  int exp_det_mc[$];
  int exp_done_mc[$];
  bit stream[0:1023];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // Monitor: every detected pulse and done pulse must match the next scoreboard entry.
  int mon_last_idx = -1;
  int mon_acc_idx  = 0;
  always @(negedge clk) begin
    if (detected) begin
      if (exp_det_idx.size() == 0) begin
        check("unexpected_detected", 1, 0);
      end else begin
        check("detected_bit_index", mon_last_idx, exp_det_idx.pop_front());
        check("detected_match_count", int'(match_count), exp_det_mc.pop_front());
      end
    end
    if (done) begin
      if (exp_done_mc.size() == 0) check("unexpected_done", 1, 0);
      else check("done_match_count", int'(match_count), exp_done_mc.pop_front());
    end
    if (rst_n && cfg_valid && cfg_ready) begin
      mon_acc_idx  = 0;
      mon_last_idx = -1;
    end
    if (rst_n && a_valid && a_ready) begin
      mon_last_idx = mon_acc_idx;
      mon_acc_idx++;
    end
  end

  function automatic bit window_hit(input logic [7:0] pat, input int len, input int i);
    for (int j = 0; j <= len; j++) begin
      if (stream[i - len + j] != pat[len - j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Predicts matches over the first n bits; returns the (unsaturated) match total.
  function automatic int model(input logic [7:0] pat, input int len, input int n);
    int seg_start = 0;
    int k = 0;
    for (int i = 0; i < n; i++) begin
      if (i - len >= seg_start && window_hit(pat, len, i)) begin
        k++;
        exp_det_idx.push_back(i);
        exp_det_mc.push_back(k > 255 ? 255 : k);
        if (!Overlap) seg_start = i + 1;
      end
    end
    return k;
  endfunction

  task automatic wait_cfg_ready(input string name);
    int c = 0;
    while (!cfg_ready && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    check(name, int'(cfg_ready), 1);
  endtask

  // stop_at < cnt ends the job early by abort (use_reset=0) or by reset (use_reset=1).
  task automatic run_job(input logic [7:0] pat, input int len, input int cnt, input int stop_at,
                         input bit use_reset, input bit gaps, input bit cfg_poke, output int mc);
    int n_acc, total, i, cyc;
    bit acc;
    n_acc = (stop_at < cnt) ? stop_at : cnt;
    total = model(pat, len, n_acc);
    mc    = total > 255 ? 255 : total;
    if (stop_at >= cnt) exp_done_mc.push_back(mc);

    a_valid = 1'b1;
    #1;
    check("a_ready_idle", int'(a_ready), 0);
    wait_cfg_ready("cfg_ready_before_job");
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = 3'(len);
    cfg_count   = 10'(cnt);
    a_valid     = 1'b0;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    if (cnt == 0) begin
      check("zero_count_done", int'(done), 1);
      check("zero_count_busy", int'(busy), 0);
    end else begin
      check("busy_in_run", int'(busy), 1);
      check("cfg_ready_in_run", int'(cfg_ready), 0);
    end

    i   = 0;
    cyc = 0;
    while (i < n_acc && cyc < 4 * cnt + 20) begin
      a_valid   = gaps ? (cyc % 2 == 0) : 1'b1;
      a         = stream[i];
      cfg_valid = cfg_poke && (cyc == 3);
      if (cfg_valid) begin
        cfg_count   = 10'd0;
        cfg_pattern = ~pat;
      end
      #1;
      if (cfg_valid) check("cfg_ready_poke", int'(cfg_ready), 0);
      acc = a_valid & a_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    cfg_valid = 1'b0;
    a_valid   = 1'b0;
    if (i < n_acc) check("bits_accepted_timeout", i, n_acc);

    if (stop_at < cnt && !use_reset) begin
      abort   = 1'b1;
      a_valid = 1'b1;
      a       = stream[i];
      #1;
      check("a_ready_abort", int'(a_ready), 0);
      @(posedge clk); #1;
      abort   = 1'b0;
      a_valid = 1'b0;
      check("abort_idle", int'(cfg_ready), 1);
      check("abort_busy", int'(busy), 0);
      check("abort_no_done", int'(done), 0);
      check("abort_match_count", int'(match_count), mc);
    end else if (stop_at < cnt) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrun_rst_detected", int'(detected), 0);
      check("midrun_rst_done", int'(done), 0);
      check("midrun_rst_busy", int'(busy), 0);
      check("midrun_rst_match_count", int'(match_count), 0);
      check("midrun_rst_cfg_ready", int'(cfg_ready), 1);
    end else begin
      wait_cfg_ready("cfg_ready_after_done");
      @(posedge clk); #1;
      check("match_count_held", int'(match_count), mc);
    end
  endtask

  initial begin
    logic [23:0] s1;
    int mc;
    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_count   = '0;
    a_valid     = 1'b0;
    a           = 1'b0;
    abort       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_detected", int'(detected), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_match_count", int'(match_count), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);

    // Scenario 1 and the same job with gapped input and a stray cfg_valid.
    s1 = 24'b0011_0101_1001_1001_1010_1000;
    for (int i = 0; i < 24; i++) stream[i] = s1[23 - i];
    run_job(8'b0011_0011, 5, 24, 1024, 1'b0, 1'b0, 1'b0, mc);
    check("scn1_match_count", int'(match_count), Overlap ? 2 : 1);
    run_job(8'b0011_0011, 5, 24, 1024, 1'b0, 1'b1, 1'b1, mc);
    check("scn5_match_count", int'(match_count), Overlap ? 2 : 1);

    // Zero-length job.
    run_job(8'h5A, 3, 0, 1024, 1'b0, 1'b0, 1'b0, mc);

    // Saturation.
    for (int i = 0; i < 300; i++) stream[i] = 1'b1;
    run_job(8'h01, 0, 300, 1024, 1'b0, 1'b0, 1'b0, mc);
    check("sat_match_count", int'(match_count), 255);

    // Abort after 5 bits, then reset mid-run followed by a fresh job.
    for (int i = 0; i < 64; i++) stream[i] = 1'($urandom_range(0, 1));
    run_job(8'h01, 0, 20, 5, 1'b0, 1'b0, 1'b0, mc);
    run_job(8'h02, 1, 40, 17, 1'b1, 1'b1, 1'b0, mc);
    run_job(8'h05, 2, 40, 1024, 1'b0, 1'b0, 1'b0, mc);

    // Randomized jobs.
    for (int j = 0; j < 12; j++) begin
      int len, cnt;
      len = int'($urandom_range(0, 3));
      cnt = int'($urandom_range(1, 80));
      for (int i = 0; i < cnt; i++) stream[i] = 1'($urandom_range(0, 1));
      run_job(8'($urandom), len, cnt, (j % 4 == 3) ? int'($urandom_range(0, cnt)) : 1024,
              1'b0, j[0], 1'b0, mc);
    end

    repeat (3) @(posedge clk);
    #1;
    check("det_queue_drained", exp_det_idx.size(), 0);
    check("done_queue_drained", exp_done_mc.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
